// File: rtl/seg_scan.sv
// seg_scan: four-digit multiplexed 7-segment scanner.
// A prescaler times each digit slot. The digit, decimal-point and
// leading-zero inputs are snapshotted once per frame, so a frame that is
// already on the display never tears. An optional blink gates the whole
// display on and off in units of full frames.
//
// Blink phase:
// state   | meaning
// PH_ON   | display visible (always the case while blink=0)
// PH_OFF  | display dark; scanning and snapshots keep running
module seg_scan #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_mask,
  input  logic        blank_lead,
  input  logic        blink,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  typedef enum logic {PH_ON, PH_OFF} phase_t;

  logic [PW-1:0] presc;
  logic [1:0]    slot;
  logic [BW-1:0] blink_cnt;
  phase_t        phase;
  logic [15:0]   snap_digits;
  logic [3:0]    snap_dp;
  logic          snap_blank;

  logic          presc_wrap;
  logic          tick;
  logic [3:0]    cur_digit;
  logic [3:0]    lead_blank;
  logic [6:0]    seg_code;
  logic          dark;

  assign presc_wrap = (presc == PRESC_LAST);
  assign tick       = presc_wrap && (slot == 2'd3);

  // Prescaler and digit slot counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc <= '0;
      slot  <= 2'd0;
    end else if (presc_wrap) begin
      presc <= '0;
      slot  <= slot + 2'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Frame snapshot, loaded only as a frame ends so a frame never mixes old and new data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      snap_digits <= 16'h0000;
      snap_dp     <= 4'b0000;
      snap_blank  <= 1'b0;
    end else if (tick) begin
      snap_digits <= digits;
      snap_dp     <= dp_mask;
      snap_blank  <= blank_lead;
    end
  end

  // Blink phase machine: counts frames and flips phase every BLINK_FRAMES frames.
  always_ff @(posedge clk) begin
    if (!rst || !blink) begin
      blink_cnt <= '0;
      phase     <= PH_ON;
    end else if (tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        phase     <= (phase == PH_ON) ? PH_OFF : PH_ON;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  // Output decode straight from registered state (no extra pipeline stage).
  always_comb begin
    cur_digit     = snap_digits[{slot, 2'b00} +: 4];
    lead_blank    = 4'b0000;
    lead_blank[3] = snap_blank && (snap_digits[15:12] == 4'd0);
    lead_blank[2] = lead_blank[3] && (snap_digits[11:8] == 4'd0);
    lead_blank[1] = lead_blank[2] && (snap_digits[7:4] == 4'd0);

    case (cur_digit)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = 7'b0111111;
    endcase

    // Dead time on the last prescaler count avoids ghosting between digits.
    dark       = presc_wrap || (phase == PH_OFF);
    seg        = lead_blank[slot] ? 7'b1111111 : seg_code;
    an         = dark ? 4'b1111 : ~(4'b0001 << slot);
    dp         = dark ? 1'b1 : ~snap_dp[slot];
    frame_tick = tick;
  end

endmodule
